// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer for an 8-LED bank.
// Two debounced push-buttons select one of five display patterns and one of
// four step rates. A free-running tick counter paces the pattern steps.

// Synchroniser, debouncer and rising-edge press detector for one raw button.
module led_btn_debounce #(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  logic        s1_q;
  logic        s2_q;
  logic        db_q;
  logic        db_prev_q;
  logic        press_q;
  logic [31:0] db_cnt_q;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
    end
  end

  // Accept a new level only after it has differed from db for DB_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q     <= 1'b0;
      db_cnt_q <= '0;
    end else if (s2_q == db_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == 32'(DB_CYCLES - 1)) begin
      db_q     <= s2_q;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + 32'd1;
    end
  end

  // One-cycle press pulse on the 0->1 transition of the debounced level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_prev_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      db_prev_q <= db_q;
      press_q   <= db_q & ~db_prev_q;
    end
  end

  assign press_o = press_q;

endmodule

module led_pattern_ctrl #(
  parameter int unsigned TICK_CYCLES = 50_000_000,
  parameter int unsigned DB_CYCLES   = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_speed,
  input  logic       pause,
  output logic [7:0] led,
  output logic [2:0] mode,
  output logic [1:0] speed,
  output logic       tick
);

  typedef enum logic [2:0] {
    FLOW_L = 3'd0,
    FLOW_R = 3'd1,
    BOUNCE = 3'd2,
    BLINK  = 3'd3,
    COUNT  = 3'd4
  } mode_e;

  // dir encoding: 0 = shifting left (towards bit 7), 1 = shifting right.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  mode_e       state_q, state_d;
  logic [7:0]  led_q, led_d;
  logic        dir_q, dir_d;
  logic [1:0]  speed_q, speed_d;
  logic [31:0] cnt_q, cnt_d;
  logic        tick_q, tick_d;

  logic        mode_press;
  logic        speed_press;
  logic [31:0] period;
  logic [7:0]  bounce_led;
  logic        state_ok;

  led_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_mode),
    .press_o (mode_press)
  );

  led_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_speed (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_speed),
    .press_o (speed_press)
  );

  assign period     = 32'(TICK_CYCLES) >> speed_q;
  assign bounce_led = (dir_q == DIR_RIGHT) ? (led_q >> 1) : (led_q << 1);
  assign state_ok   = state_q inside {FLOW_L, FLOW_R, BOUNCE, BLINK, COUNT};

  // State, LED, rate and tick counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FLOW_L;
      led_q   <= 8'h01;
      dir_q   <= DIR_LEFT;
      speed_q <= 2'd0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      speed_q <= speed_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  // Next-state: presses restart the period and win over a coincident step.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    dir_d   = dir_q;
    speed_d = speed_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;

    if (speed_press) speed_d = speed_q + 2'd1;

    if (mode_press || speed_press) begin
      cnt_d = '0;
    end else if (!pause) begin
      if (cnt_q == period - 32'd1) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    if (mode_press) begin
      dir_d = DIR_LEFT;
      case (state_q)
        FLOW_L:  begin state_d = FLOW_R; led_d = 8'h80; end
        FLOW_R:  begin state_d = BOUNCE; led_d = 8'h01; end
        BOUNCE:  begin state_d = BLINK;  led_d = 8'h00; end
        BLINK:   begin state_d = COUNT;  led_d = 8'h00; end
        default: begin state_d = FLOW_L; led_d = 8'h01; end
      endcase
    end else if (tick_d) begin
      case (state_q)
        FLOW_L:  led_d = {led_q[6:0], led_q[7]};
        FLOW_R:  led_d = {led_q[0], led_q[7:1]};
        BOUNCE: begin
          led_d = bounce_led;
          if (bounce_led == 8'h80)      dir_d = DIR_RIGHT;
          else if (bounce_led == 8'h01) dir_d = DIR_LEFT;
        end
        BLINK:   led_d = ~led_q;
        COUNT:   led_d = led_q + 8'd1;
        default: led_d = 8'h01;
      endcase
    end

    // Undefined encodings recover to the first pattern.
    if (!state_ok) begin
      state_d = FLOW_L;
      led_d   = 8'h01;
      dir_d   = DIR_LEFT;
    end
  end

  assign led   = led_q;
  assign mode  = state_q;
  assign speed = speed_q;
  assign tick  = tick_q;

endmodule
